// File: rtl/dwt_line_framer.sv
// dwt_line_framer: frames a raw {odd, even} pair stream for one tile in front of
// the 1-D 9/7 lifting unit. It drives sof/eol from the per-tile width/height,
// checks the upstream s_last_i alignment, and pulses done_o once the tile has
// been fully issued.
// Optional build macro DWT_FRAMER_STATS_EN adds the stall_cnt_o/frame_cnt_o
// statistics ports. Without it, those ports and counters are absent.
module dwt_line_framer #(
  parameter int DataWidth       = 16,
  parameter int MaximumSideSize = 512,
  parameter int CntWidth        = $clog2(MaximumSideSize) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [CntWidth-1:0]    cfg_width_i,
  input  logic [CntWidth-1:0]    cfg_height_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   s_last_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
`ifdef DWT_FRAMER_STATS_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [15:0]            frame_cnt_o
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CntWidth-1:0] MAX_W = CntWidth'(MaximumSideSize / 2);
  localparam logic [CntWidth-1:0] MAX_H = CntWidth'(MaximumSideSize);
  localparam logic [CntWidth-1:0] ONE   = CntWidth'(1);

  logic [1:0]          state;
  logic [CntWidth-1:0] col;
  logic [CntWidth-1:0] row;
  // Width and height are held as W-1 / H-1 so the end-of-line and end-of-tile
  // tests are plain equality compares against the running counters.
  logic [CntWidth-1:0] w_m1;
  logic [CntWidth-1:0] h_m1;
  logic                err;

  logic in_run;
  logic beat;
  logic end_of_line;
  logic last_beat;
  logic cfg_bad;

  assign in_run      = (state == RUN);
  assign beat        = in_run & s_valid_i & m_ready_i;
  assign end_of_line = (col == w_m1);
  assign last_beat   = end_of_line & (row == h_m1);
  assign cfg_bad     = (cfg_width_i == '0) || (cfg_width_i > MAX_W) ||
                       (cfg_height_i == '0) || (cfg_height_i > MAX_H);

  // Zero-latency pass-through; the side-band is meaningful only with m_valid_o.
  assign cfg_ready_o = (state == IDLE);
  assign s_ready_o   = in_run & m_ready_i;
  assign m_valid_o   = in_run & s_valid_i;
  assign m_data_o    = s_data_i;
  assign m_sof_o     = in_run && (col == '0) && (row == '0);
  assign m_eol_o     = in_run && end_of_line;
  assign busy_o      = (state == RUN) || (state == DONE);
  assign done_o      = (state == DONE);
  assign err_o       = err;

  // Tile sequencer: config capture, beat counting and sticky error tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      w_m1  <= '0;
      h_m1  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid_i) begin
            err  <= cfg_bad;
            w_m1 <= cfg_width_i - ONE;
            h_m1 <= cfg_height_i - ONE;
            col  <= '0;
            row  <= '0;
            if (!cfg_bad) state <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            // Framing follows the configured counts; s_last_i only feeds the check.
            if (s_last_i != last_beat) err <= 1'b1;
            if (end_of_line) begin
              col <= '0;
              row <= row + ONE;
              if (last_beat) state <= DONE;
            end else begin
              col <= col + ONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DWT_FRAMER_STATS_EN
  // Free-running statistics: stalled RUN cycles and completed tiles, wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      frame_cnt_o <= '0;
    end else begin
      if (in_run && s_valid_i && !m_ready_i) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (state == DONE) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dwt_line_framer.sv
// tb_dwt_line_framer: scoreboard bench for dwt_line_framer. Expected beats
// (data, sof, eol) are queued when driven and compared when the DUT accepts them.
module tb_dwt_line_framer;

  localparam int DW  = 16;
  localparam int MSS = 512;
  localparam int CW  = $clog2(MSS) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_width = '0;
  logic [CW-1:0] cfg_height = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [2*DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_sof;
  logic          m_eol;
  logic [2*DW-1:0] m_data;
  logic          busy;
  logic          done;
  logic          err;
`ifdef DWT_FRAMER_STATS_EN
  logic [31:0]   stall_cnt;
  logic [15:0]   frame_cnt;
`endif

  dwt_line_framer #(.DataWidth(DW), .MaximumSideSize(MSS)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_width_i(cfg_width), .cfg_height_i(cfg_height),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_sof_o(m_sof), .m_eol_o(m_eol),
    .m_data_o(m_data), .busy_o(busy), .done_o(done), .err_o(err)
`ifdef DWT_FRAMER_STATS_EN
    , .stall_cnt_o(stall_cnt), .frame_cnt_o(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sof;
    logic          eol;
    logic [2*DW-1:0] data;
  } beat_t;

  beat_t q[$];
  int    n_chk = 0;
  int    n_err = 0;
  bit    exp_err = 1'b0;
  int    stalls = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs expected while the framer sits in IDLE (also the reset values).
  task automatic chk_idle(input string tag);
    chk({tag, ".cfg_ready"}, cfg_ready, 1);
    chk({tag, ".s_ready"}, s_ready, 0);
    chk({tag, ".m_valid"}, m_valid, 0);
    chk({tag, ".sof_eol"}, {m_sof, m_eol}, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
  endtask

  // Present one config; returns at posedge+1 after it was taken.
  task automatic cfg(input int w, input int h, input bit bad);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_width = CW'(w);
    cfg_height = CW'(h);
    @(negedge clk);
    chk("cfg.ready", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    exp_err = bad;
    chk("cfg.err", err, bad);
    chk("cfg.busy", busy, !bad);
  endtask

  // Drive up to nbeats pairs of a w x h tile. bad>=0 places s_last on that beat
  // instead of the true last one. stall toggles m_ready 1/0 each cycle.
  task automatic run_tile(input int w, input int h, input int bad, input int nbeats,
                          input bit stall);
    int    n = w * h;
    int    i = 0;
    int    cyc = 0;
    bit    tog = 1'b1;
    bit    have = 1'b0;
    beat_t e;
    stalls = 0;
    while (i < nbeats && cyc < 4000) begin
      if (!have) begin
        e.sof  = (i == 0);
        e.eol  = ((i % w) == w - 1);
        e.data = $urandom;
        q.push_back(e);
        have = 1'b1;
      end
      s_valid = 1'b1;
      s_data  = q[q.size()-1].data;
      s_last  = (bad >= 0) ? (i == bad) : (i == n - 1);
      m_ready = stall ? tog : 1'b1;
      tog = !tog;
      @(negedge clk);
      chk("beat.m_valid", m_valid, 1);
      chk("beat.s_ready", s_ready, m_ready);
      chk("beat.data", m_data, q[0].data);
      chk("beat.sof", m_sof, q[0].sof);
      chk("beat.eol", m_eol, q[0].eol);
      chk("beat.err", err, exp_err);
      chk("beat.done", done, 0);
      if (m_ready) begin
        void'(q.pop_front());
        if (s_last != (i == n - 1)) exp_err = 1'b1;
        i++;
        have = 1'b0;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 4000) chk("tile.timeout", cyc, 0);
    s_last  = 1'b0;
    m_ready = 1'b1;
  endtask

  // DONE cycle then return to IDLE; s_valid held high to show it is not consumed.
  task automatic done_phase();
    s_valid = 1'b1;
    @(negedge clk);
    chk("done.pulse", done, 1);
    chk("done.busy", busy, 1);
    chk("done.m_valid", m_valid, 0);
    chk("done.s_ready", s_ready, 0);
    chk("done.cfg_ready", cfg_ready, 0);
    chk("done.err", err, exp_err);
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle("post_done");
    chk("post_done.err", err, exp_err);
    chk("post_done.queue", q.size(), 0);
    s_valid = 1'b0;
  endtask

  initial begin
`ifdef DWT_FRAMER_STATS_EN
    int s0;
    int f0;
`endif
    #2;
    chk_idle("reset");
    chk("reset.err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    // W=4,H=2: sof on beat 0, eol on beats 3 and 7.
    cfg(4, 2, 0);
    run_tile(4, 2, -1, 8, 0);
    done_phase();

    // W=1,H=1: single beat with sof=eol=1.
    cfg(1, 1, 0);
    run_tile(1, 1, -1, 1, 0);
    done_phase();

    // W=3,H=2 under toggling m_ready: outputs hold while stalled.
`ifdef DWT_FRAMER_STATS_EN
    s0 = stall_cnt;
    f0 = frame_cnt;
`endif
    cfg(3, 2, 0);
    run_tile(3, 2, -1, 6, 1);
    done_phase();
`ifdef DWT_FRAMER_STATS_EN
    chk("stats.stall", stall_cnt - s0, stalls);
    chk("stats.frame", frame_cnt - f0, 1);
`endif

    // W=1,H=3 with stalls: every beat carries eol.
    cfg(1, 3, 0);
    run_tile(1, 3, -1, 3, 1);
    done_phase();

    // Early s_last on beat 2 of W=4,H=1: sticky err, framing continues by count.
    cfg(4, 1, 0);
    run_tile(4, 1, 2, 4, 0);
    chk("early_last.err_set", exp_err, 1);
    done_phase();
    cfg(4, 1, 0);
    run_tile(4, 1, -1, 4, 0);
    done_phase();

    // Illegal configs stay in IDLE with err set and no input consumed.
    cfg(0, 1, 1);
    s_valid = 1'b1;
    @(negedge clk);
    chk_idle("bad_cfg.idle");
    chk("bad_cfg.err", err, 1);
    s_valid = 1'b0;
    cfg(257, 1, 1);
    cfg(4, 0, 1);
    cfg(1, 513, 1);

    // Largest legal width.
    cfg(256, 1, 0);
    run_tile(256, 1, -1, 256, 0);
    done_phase();

    // Asynchronous reset mid-tile after 5 beats of W=4,H=4.
    cfg(4, 4, 0);
    run_tile(4, 4, -1, 5, 0);
    s_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk_idle("mid_reset");
    chk("mid_reset.err", err, 0);
`ifdef DWT_FRAMER_STATS_EN
    chk("mid_reset.frame_cnt", frame_cnt, 0);
    chk("mid_reset.stall_cnt", stall_cnt, 0);
`endif
    s_valid = 1'b0;
    q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cfg(2, 1, 0);
    run_tile(2, 1, -1, 2, 0);
    done_phase();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
